// File: rtl/elevator_pkg.sv
// Shared types for the elevator subsystem: car states, direction encoding and
// the one-hot floor mask helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Widest building the mask helper supports; callers truncate to their own FLOORS.
  localparam int MAX_FLOORS = 64;

  function automatic logic [MAX_FLOORS-1:0] floor_mask(input int unsigned f);
    floor_mask = MAX_FLOORS'(1) << f;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: reports whether any effective call lies above or
// below the given floor, and whether the floor itself is being called.
module elevator_req_scan #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0]  eff,
  input  logic [FLOOR_W-1:0] floor,
  output logic               any_above,
  output logic               any_below,
  output logic               hit
);

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(floor))      any_above = any_above | eff[i];
      else if (i < int'(floor)) any_below = any_below | eff[i];
    end
    hit = eff[floor];
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator car controller with travel and door-dwell timing.
// Optional build macro ELEVATOR_ESTOP_EN adds an estop input that stalls the car.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = $clog2(FLOORS),
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 6
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ELEVATOR_ESTOP_EN
  input  logic               estop,
`endif
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir,
  output logic               moving,
  output logic               door_open,
  output logic               arrive,
  output logic [FLOORS-1:0]  pending
);

  localparam int TCNT_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DCNT_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TRAVEL_CYC - 1);
  localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  state_t              state_q, state_n;
  logic [FLOOR_W-1:0]  floor_q, floor_n, floor_step;
  logic                dir_q, dir_n;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_n;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_n;
  logic [FLOORS-1:0]   pending_q, pending_n, eff, clr;
  logic                arrive_q, arrive_n, moving_q, door_q;
  logic                any_above, any_below, hit, hit_step;
  logic                ahead, behind, at_top, at_bot, stall;

`ifdef ELEVATOR_ESTOP_EN
  assign stall = estop;
`else
  assign stall = 1'b0;
`endif

  // Requests arriving this cycle count immediately, not one cycle late.
  assign eff = pending_q | req;

  elevator_req_scan #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_scan (
    .eff       (eff),
    .floor     (floor_q),
    .any_above (any_above),
    .any_below (any_below),
    .hit       (hit)
  );

  assign at_top = (floor_q == TOP_FLOOR);
  assign at_bot = (floor_q == '0);
  assign ahead  = (dir_q == DIR_UP) ? any_above : any_below;
  assign behind = (dir_q == DIR_UP) ? any_below : any_above;

  // Saturating one-floor step so the car can never leave the shaft.
  always_comb begin
    floor_step = floor_q;
    if (dir_q == DIR_UP && !at_top)      floor_step = floor_q + 1'b1;
    else if (dir_q == DIR_DN && !at_bot) floor_step = floor_q - 1'b1;
  end

  assign hit_step = eff[floor_step];

  always_comb begin
    // NOTE: every combinational output is defaulted first so no branch can infer a latch.
    state_n  = state_q;
    floor_n  = floor_q;
    dir_n    = dir_q;
    tcnt_n   = tcnt_q;
    dcnt_n   = dcnt_q;
    arrive_n = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          state_n = DOOR;
          dcnt_n  = '0;
        end else if (!stall && (ahead || behind)) begin
          state_n = MOVE;
          tcnt_n  = '0;
          if (!ahead) dir_n = ~dir_q;
        end
      end
      MOVE: begin
        if (!stall) begin
          if (tcnt_q == TCNT_LAST) begin
            tcnt_n   = '0;
            floor_n  = floor_step;
            arrive_n = (floor_step != floor_q);
            if (hit_step) begin
              state_n = DOOR;
              dcnt_n  = '0;
            end else if (floor_step == floor_q) begin
              state_n = IDLE;
            end
          end else begin
            tcnt_n = tcnt_q + 1'b1;
          end
        end
      end
      DOOR: begin
        // A call for this floor while the door is open just extends the dwell.
        if (hit) begin
          dcnt_n = '0;
        end else if (!stall) begin
          if (dcnt_q == DCNT_LAST) begin
            if (ahead || behind) begin
              state_n = MOVE;
              tcnt_n  = '0;
              if (!ahead) dir_n = ~dir_q;
            end else begin
              state_n = IDLE;
            end
          end else begin
            dcnt_n = dcnt_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Direction is settled only when leaving a parked state; end floors pin it.
    if (state_q != MOVE && state_n != state_q) begin
      if (at_top)      dir_n = DIR_DN;
      else if (at_bot) dir_n = DIR_UP;
    end

    clr       = (state_n == DOOR) ? FLOORS'(floor_mask(32'(floor_n))) : '0;
    pending_n = eff & ~clr;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_UP;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      pending_q <= '0;
      arrive_q  <= 1'b0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      floor_q   <= floor_n;
      dir_q     <= dir_n;
      tcnt_q    <= tcnt_n;
      dcnt_q    <= dcnt_n;
      pending_q <= pending_n;
      arrive_q  <= arrive_n;
      moving_q  <= (state_n == MOVE);
      door_q    <= (state_n == DOOR);
    end
  end

  assign floor     = floor_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign door_open = door_q;
  assign arrive    = arrive_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Scoreboard bench for elevator_ctrl_n: expected arrive / door events are queued
// when a call is issued and matched against the car's observed events.
module tb_elevator_ctrl_n;

  typedef enum int {EV_ARR, EV_OPEN, EV_CLOSE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       fl;
  } ev_t;

  logic       clk, rst;
  logic [7:0] req;
  logic [2:0] floor;
  logic       dir, moving, door_open, arrive;
  logic [7:0] pending;
`ifdef ELEVATOR_ESTOP_EN
  logic       estop;
`endif

  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  k;
  logic door_prev = 1'b0;
  ev_t exp_q[$];

  elevator_ctrl_n #(
    .FLOORS     (8),
    .TRAVEL_CYC (4),
    .DOOR_CYC   (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ELEVATOR_ESTOP_EN
    .estop     (estop),
`endif
    .req       (req),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(ev_kind_t kd, int c, int f);
    ev_t e;
    e.kind = kd;
    e.cyc  = c;
    e.fl   = f;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_kind_t kd);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_evt", 32'(kd), 32'hFF);
    end else begin
      e = exp_q.pop_front();
      check("evt_kind", 32'(kd), 32'(e.kind));
      check("evt_cyc", 32'(cyc), 32'(e.cyc));
      check("evt_floor", 32'(floor), 32'(e.fl));
    end
  endtask

  // Event monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (arrive) observe(EV_ARR);
    if (door_open && !door_prev) observe(EV_OPEN);
    if (!door_open && door_prev) observe(EV_CLOSE);
    door_prev = door_open;
  end

  // Called on a falling edge; the request is sampled at edge cyc+1.
  task automatic pulse(input logic [7:0] m);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_floor"}, 32'(floor), 32'd0);
    check({tag, "_dir"}, 32'(dir), 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_moving"}, 32'(moving), 32'd0);
    check({tag, "_door"}, 32'(door_open), 32'd0);
    check({tag, "_arrive"}, 32'(arrive), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    rst = 1'b1;
`ifdef ELEVATOR_ESTOP_EN
    estop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst0");

    // Call at the current floor: door opens for six cycles, nothing latched.
    k = cyc + 1;
    push(EV_OPEN, k, 0);
    push(EV_CLOSE, k + 6, 0);
    pulse(8'h01);
    check("t1_pending", 32'(pending), 32'd0);
    check("t1_door", 32'(door_open), 32'd1);
    wait_edge(k + 8);
    check("t1_idle_moving", 32'(moving), 32'd0);
    check("t1_idle_door", 32'(door_open), 32'd0);
    wait_drain(20);

    // Single trip 0 -> 5.
    k = cyc + 1;
    for (int i = 1; i <= 5; i++) push(EV_ARR, k + 4 * i, i);
    push(EV_OPEN, k + 20, 5);
    push(EV_CLOSE, k + 26, 5);
    pulse(8'h20);
    check("t2_moving", 32'(moving), 32'd1);
    check("t2_pending", 32'(pending), 32'h20);
    wait_edge(k + 20);
    check("t2_pending_clr", 32'(pending), 32'd0);
    wait_drain(40);
    check("t2_floor", 32'(floor), 32'd5);

    apply_reset();
    check_reset_state("rst1");

    // SCAN: up to 6 picking up 5 on the way, then reverse down to 1.
    k = cyc + 1;
    for (int i = 1; i <= 5; i++) push(EV_ARR, k + 4 * i, i);
    push(EV_OPEN, k + 20, 5);
    push(EV_CLOSE, k + 26, 5);
    push(EV_ARR, k + 30, 6);
    push(EV_OPEN, k + 30, 6);
    push(EV_CLOSE, k + 36, 6);
    for (int i = 1; i <= 5; i++) push(EV_ARR, k + 36 + 4 * i, 6 - i);
    push(EV_OPEN, k + 56, 1);
    push(EV_CLOSE, k + 62, 1);
    pulse(8'h40);
    wait_edge(k + 12);
    check("t3_floor3", 32'(floor), 32'd3);
    check("t3_dir_up", 32'(dir), 32'd0);
    pulse(8'h22);
    check("t3_pending", 32'(pending), 32'h62);
    wait_edge(k + 26);
    check("t3_leave5_dir", 32'(dir), 32'd0);
    check("t3_leave5_moving", 32'(moving), 32'd1);
    wait_edge(k + 36);
    check("t3_flip_dir", 32'(dir), 32'd1);
    check("t3_flip_moving", 32'(moving), 32'd1);
    wait_drain(80);
    check("t3_floor1", 32'(floor), 32'd1);

    // Top floor: repeat call during dwell restarts the door timer.
    k = cyc + 1;
    for (int i = 1; i <= 6; i++) push(EV_ARR, k + 4 * i, 1 + i);
    push(EV_OPEN, k + 24, 7);
    push(EV_CLOSE, k + 35, 7);
    pulse(8'h80);
    wait_edge(k + 28);
    check("t4_door", 32'(door_open), 32'd1);
    pulse(8'h80);
    check("t4_pending", 32'(pending), 32'd0);
    wait_edge(k + 34);
    check("t4_still_open", 32'(door_open), 32'd1);
    wait_drain(20);
    repeat (4) @(negedge clk);
    check("t4_floor", 32'(floor), 32'd7);
    check("t4_moving", 32'(moving), 32'd0);

    apply_reset();
    check_reset_state("rst2");

    // Reset in the middle of travel between floors 2 and 3.
    k = cyc + 1;
    push(EV_ARR, k + 4, 1);
    push(EV_ARR, k + 8, 2);
    pulse(8'h90);
    wait_edge(k + 10);
    check("t5_pending", 32'(pending), 32'h90);
    check("t5_floor", 32'(floor), 32'd2);
    check("t5_moving", 32'(moving), 32'd1);
    apply_reset();
    check_reset_state("t5_rst");
    repeat (6) @(negedge clk);
    check("t5_no_retain_moving", 32'(moving), 32'd0);
    check("t5_no_retain_pending", 32'(pending), 32'd0);
    wait_drain(10);

`ifdef ELEVATOR_ESTOP_EN
    // Ten-cycle emergency stop mid-travel delays the next arrival by ten cycles.
    k = cyc + 1;
    push(EV_ARR, k + 4, 1);
    push(EV_ARR, k + 18, 2);
    push(EV_ARR, k + 22, 3);
    push(EV_OPEN, k + 22, 3);
    push(EV_CLOSE, k + 28, 3);
    pulse(8'h08);
    wait_edge(k + 5);
    estop = 1'b1;
    repeat (10) @(negedge clk);
    estop = 1'b0;
    check("t6_floor_held", 32'(floor), 32'd1);
    check("t6_moving_held", 32'(moving), 32'd1);
    wait_drain(40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
